// File: rtl/hazard_fwd_ctrl.sv
// hazard_fwd_ctrl: operand forwarding from NSTAGE downstream stages, load-use
// and busy stall detection, branch flush sequencing, a stall watchdog and
// saturating stall/flush performance counters. Sits between decode and execute.
module hazard_fwd_ctrl #(
  parameter int DWIDTH       = 32,
  parameter int AWIDTH       = 5,
  parameter int NSTAGE       = 3,
  parameter int FLUSH_CYCLES = 2,
  parameter int MAX_STALL    = 15,
  parameter int CWIDTH       = 16
) (
  input  logic                     hz_clk,
  input  logic                     hz_rst,
  input  logic                     hz_i_ce,
  input  logic [AWIDTH-1:0]        hz_i_addr_rs1,
  input  logic [AWIDTH-1:0]        hz_i_addr_rs2,
  input  logic [DWIDTH-1:0]        hz_i_data_rs1,
  input  logic [DWIDTH-1:0]        hz_i_data_rs2,
  input  logic [NSTAGE-1:0]        hz_i_stage_valid,
  input  logic [NSTAGE-1:0]        hz_i_stage_we,
  input  logic [NSTAGE-1:0]        hz_i_stage_ok,
  input  logic [NSTAGE*AWIDTH-1:0] hz_i_stage_addr_rd,
  input  logic [NSTAGE*DWIDTH-1:0] hz_i_stage_data_rd,
  input  logic                     hz_i_alu_busy,
  input  logic                     hz_i_change_pc,
  input  logic                     hz_i_clr,
  output logic [DWIDTH-1:0]        hz_o_data_rs1,
  output logic [DWIDTH-1:0]        hz_o_data_rs2,
  output logic                     hz_o_stall,
  output logic                     hz_o_flush,
  output logic                     hz_o_timeout,
  output logic [CWIDTH-1:0]        hz_o_stall_cnt,
  output logic [CWIDTH-1:0]        hz_o_flush_cnt
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  localparam logic [3:0]        LP_FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);
  localparam logic [7:0]        LP_MAX_STALL    = 8'(MAX_STALL);
  localparam logic [CWIDTH-1:0] LP_CNT_MAX      = '1;

  state_t            r_state;
  logic [3:0]        r_flush_cnt;
  logic [7:0]        r_run_cnt;
  logic              r_timeout;
  logic [CWIDTH-1:0] r_stall_cnt;
  logic [CWIDTH-1:0] r_flush_ev_cnt;

  logic [DWIDTH-1:0] w_fwd_rs1;
  logic [DWIDTH-1:0] w_fwd_rs2;
  logic              w_ok_rs1;
  logic              w_ok_rs2;
  logic              w_haz;
  logic              w_flush;
  logic              w_stall;
  logic [7:0]        w_run_nxt;

  // Operand select: scan oldest to youngest so the youngest matching stage wins.
  always_comb begin
    // NOTE: every signal gets a default before any condition, so no path
    // leaves a value unassigned and no latch is inferred.
    w_fwd_rs1 = hz_i_data_rs1;
    w_fwd_rs2 = hz_i_data_rs2;
    w_ok_rs1  = 1'b1;
    w_ok_rs2  = 1'b1;
    // NOTE: blocking assignments here; a later (younger) match overwrites an
    // earlier (older) one within the same evaluation.
    for (int i = NSTAGE - 1; i >= 0; i--) begin
      if (hz_i_stage_valid[i] && hz_i_stage_we[i]) begin
        if (hz_i_stage_addr_rd[i*AWIDTH +: AWIDTH] == hz_i_addr_rs1) begin
          w_fwd_rs1 = hz_i_stage_data_rd[i*DWIDTH +: DWIDTH];
          w_ok_rs1  = hz_i_stage_ok[i];
        end
        if (hz_i_stage_addr_rd[i*AWIDTH +: AWIDTH] == hz_i_addr_rs2) begin
          w_fwd_rs2 = hz_i_stage_data_rd[i*DWIDTH +: DWIDTH];
          w_ok_rs2  = hz_i_stage_ok[i];
        end
      end
    end
    // x0 reads as zero and can never create a dependency.
    if (hz_i_addr_rs1 == '0) begin
      w_fwd_rs1 = '0;
      w_ok_rs1  = 1'b1;
    end
    if (hz_i_addr_rs2 == '0) begin
      w_fwd_rs2 = '0;
      w_ok_rs2  = 1'b1;
    end
  end

  assign w_haz   = hz_i_ce & (~w_ok_rs1 | ~w_ok_rs2 | hz_i_alu_busy);
  assign w_flush = hz_rst | hz_i_change_pc | (r_flush_cnt != 4'd0);
  // A flush kills the decode slot anyway, so it suppresses the stall.
  assign w_stall = w_haz & ~w_flush & ~hz_rst;

  assign hz_o_data_rs1  = w_fwd_rs1;
  assign hz_o_data_rs2  = w_fwd_rs2;
  assign hz_o_stall     = w_stall;
  assign hz_o_flush     = w_flush;
  assign hz_o_timeout   = r_timeout;
  assign hz_o_stall_cnt = r_stall_cnt;
  assign hz_o_flush_cnt = r_flush_ev_cnt;

  // Flush window: a redirect (re)loads the remaining-cycle count.
  always_ff @(posedge hz_clk or posedge hz_rst) begin
    // NOTE: reset is asynchronous so flush/stall react mid-cycle; every
    // register in this block is cleared in the reset branch.
    if (hz_rst) begin
      r_flush_cnt <= 4'd0;
    end else if (hz_i_change_pc) begin
      // NOTE: non-blocking assignment for all sequential state.
      r_flush_cnt <= LP_FLUSH_RELOAD;
    end else if (r_flush_cnt != 4'd0) begin
      r_flush_cnt <= r_flush_cnt - 4'd1;
    end
  end

  // Pipeline-control state tracking; flush takes priority over stall.
  always_ff @(posedge hz_clk or posedge hz_rst) begin
    if (hz_rst) begin
      r_state <= ST_RUN;
    end else begin
      unique case (r_state)
        ST_RUN: begin
          if (w_flush)      r_state <= ST_FLUSH;
          else if (w_stall) r_state <= ST_STALL;
        end
        ST_STALL: begin
          if (hz_i_change_pc) r_state <= ST_FLUSH;
          else if (!w_stall)  r_state <= ST_RUN;
        end
        ST_FLUSH: begin
          if ((r_flush_cnt == 4'd0) && !hz_i_change_pc) r_state <= ST_RUN;
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  // Next value of the consecutive-stall run length, saturating at MAX_STALL.
  always_comb begin
    w_run_nxt = 8'd0;
    if (w_stall) begin
      w_run_nxt = (r_run_cnt >= LP_MAX_STALL) ? LP_MAX_STALL : r_run_cnt + 8'd1;
    end
  end

  // Watchdog: sticky flag raised on the edge the run length reaches MAX_STALL.
  always_ff @(posedge hz_clk or posedge hz_rst) begin
    if (hz_rst) begin
      r_run_cnt <= 8'd0;
      r_timeout <= 1'b0;
    end else if (hz_i_clr) begin
      r_run_cnt <= 8'd0;
      r_timeout <= 1'b0;
    end else begin
      r_run_cnt <= w_run_nxt;
      if (w_stall && (w_run_nxt == LP_MAX_STALL)) r_timeout <= 1'b1;
    end
  end

  // Saturating performance counters; clear beats a coincident event.
  always_ff @(posedge hz_clk or posedge hz_rst) begin
    if (hz_rst) begin
      r_stall_cnt    <= '0;
      r_flush_ev_cnt <= '0;
    end else if (hz_i_clr) begin
      r_stall_cnt    <= '0;
      r_flush_ev_cnt <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != LP_CNT_MAX))
        r_stall_cnt <= r_stall_cnt + 1'b1;
      if (hz_i_change_pc && (r_flush_ev_cnt != LP_CNT_MAX))
        r_flush_ev_cnt <= r_flush_ev_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed testbench for hazard_fwd_ctrl with hand-computed expectations.
module tb_hazard_fwd_ctrl;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NS = 3;
  localparam int CW = 16;

  logic             hz_clk = 1'b0;
  logic             hz_rst;
  logic             hz_i_ce;
  logic [AW-1:0]    hz_i_addr_rs1, hz_i_addr_rs2;
  logic [DW-1:0]    hz_i_data_rs1, hz_i_data_rs2;
  logic [NS-1:0]    hz_i_stage_valid, hz_i_stage_we, hz_i_stage_ok;
  logic [NS*AW-1:0] hz_i_stage_addr_rd;
  logic [NS*DW-1:0] hz_i_stage_data_rd;
  logic             hz_i_alu_busy, hz_i_change_pc, hz_i_clr;
  logic [DW-1:0]    hz_o_data_rs1, hz_o_data_rs2;
  logic             hz_o_stall, hz_o_flush, hz_o_timeout;
  logic [CW-1:0]    hz_o_stall_cnt, hz_o_flush_cnt;

  int checks = 0;
  int errors = 0;

  always #5 hz_clk = ~hz_clk;

  hazard_fwd_ctrl #(
    .DWIDTH(DW), .AWIDTH(AW), .NSTAGE(NS),
    .FLUSH_CYCLES(2), .MAX_STALL(15), .CWIDTH(CW)
  ) dut (
    .hz_clk(hz_clk), .hz_rst(hz_rst), .hz_i_ce(hz_i_ce),
    .hz_i_addr_rs1(hz_i_addr_rs1), .hz_i_addr_rs2(hz_i_addr_rs2),
    .hz_i_data_rs1(hz_i_data_rs1), .hz_i_data_rs2(hz_i_data_rs2),
    .hz_i_stage_valid(hz_i_stage_valid), .hz_i_stage_we(hz_i_stage_we),
    .hz_i_stage_ok(hz_i_stage_ok), .hz_i_stage_addr_rd(hz_i_stage_addr_rd),
    .hz_i_stage_data_rd(hz_i_stage_data_rd), .hz_i_alu_busy(hz_i_alu_busy),
    .hz_i_change_pc(hz_i_change_pc), .hz_i_clr(hz_i_clr),
    .hz_o_data_rs1(hz_o_data_rs1), .hz_o_data_rs2(hz_o_data_rs2),
    .hz_o_stall(hz_o_stall), .hz_o_flush(hz_o_flush), .hz_o_timeout(hz_o_timeout),
    .hz_o_stall_cnt(hz_o_stall_cnt), .hz_o_flush_cnt(hz_o_flush_cnt)
  );

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge hz_clk);
    #1;
  endtask

  // Let combinational outputs settle after an input change.
  task automatic settle();
    #1;
  endtask

  task automatic set_stage(input int idx, input logic v, input logic we, input logic ok,
                           input logic [AW-1:0] rd, input logic [DW-1:0] d);
    hz_i_stage_valid[idx]            = v;
    hz_i_stage_we[idx]               = we;
    hz_i_stage_ok[idx]               = ok;
    hz_i_stage_addr_rd[idx*AW +: AW] = rd;
    hz_i_stage_data_rd[idx*DW +: DW] = d;
  endtask

  task automatic idle();
    hz_i_ce = 1'b0;          hz_i_addr_rs1 = '0;     hz_i_addr_rs2 = '0;
    hz_i_data_rs1 = '0;      hz_i_data_rs2 = '0;
    hz_i_stage_valid = '0;   hz_i_stage_we = '0;     hz_i_stage_ok = '1;
    hz_i_stage_addr_rd = '0; hz_i_stage_data_rd = '0;
    hz_i_alu_busy = 1'b0;    hz_i_change_pc = 1'b0;  hz_i_clr = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    hz_rst = 1'b1; hz_i_ce = 1'b1; hz_i_alu_busy = 1'b1;
    repeat (2) @(posedge hz_clk);
    #2;
    checks++; if (hz_o_flush !== 1'b1) begin errors++; $display("FAIL reset_flush: got %0b want 1", hz_o_flush); end
    checks++; if (hz_o_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0b want 0", hz_o_stall); end
    hz_rst = 1'b0; hz_i_ce = 1'b0; hz_i_alu_busy = 1'b0;
    settle();
    checks++; if (hz_o_flush !== 1'b0) begin errors++; $display("FAIL post_reset_flush: got %0b want 0", hz_o_flush); end
    checks++; if (hz_o_stall_cnt !== 16'd0) begin errors++; $display("FAIL post_reset_stall_cnt: got %0d want 0", hz_o_stall_cnt); end
    checks++; if (hz_o_flush_cnt !== 16'd0) begin errors++; $display("FAIL post_reset_flush_cnt: got %0d want 0", hz_o_flush_cnt); end
    checks++; if (hz_o_timeout !== 1'b0) begin errors++; $display("FAIL post_reset_timeout: got %0b want 0", hz_o_timeout); end
    tick();
  endtask

  task automatic test_priority_fwd();
    idle();
    set_stage(0, 1, 1, 1, 5'd5, 32'hAAAA0000);
    set_stage(2, 1, 1, 1, 5'd5, 32'h0000BBBB);
    hz_i_addr_rs1 = 5'd5; hz_i_data_rs1 = 32'h1111;
    hz_i_addr_rs2 = 5'd3; hz_i_data_rs2 = 32'h5555;
    hz_i_ce = 1'b1;
    settle();
    checks++; if (hz_o_data_rs1 !== 32'hAAAA0000) begin errors++; $display("FAIL prio_stage0: got %h want aaaa0000", hz_o_data_rs1); end
    checks++; if (hz_o_data_rs2 !== 32'h5555) begin errors++; $display("FAIL prio_nomatch_rf: got %h want 00005555", hz_o_data_rs2); end
    checks++; if (hz_o_stall !== 1'b0) begin errors++; $display("FAIL prio_stall: got %0b want 0", hz_o_stall); end
    set_stage(0, 0, 1, 1, 5'd5, 32'hAAAA0000);
    settle();
    checks++; if (hz_o_data_rs1 !== 32'h0000BBBB) begin errors++; $display("FAIL prio_stage2: got %h want 0000bbbb", hz_o_data_rs1); end
    set_stage(0, 1, 0, 1, 5'd5, 32'hAAAA0000);
    settle();
    checks++; if (hz_o_data_rs1 !== 32'h0000BBBB) begin errors++; $display("FAIL prio_no_we: got %h want 0000bbbb", hz_o_data_rs1); end
    set_stage(1, 1, 1, 1, 5'd5, 32'h00000011);
    settle();
    checks++; if (hz_o_data_rs1 !== 32'h00000011) begin errors++; $display("FAIL prio_stage1: got %h want 00000011", hz_o_data_rs1); end
    idle();
    tick();
  endtask

  task automatic test_x0_guard();
    idle();
    set_stage(1, 1, 1, 0, 5'd0, 32'hFFFFFFFF);
    hz_i_addr_rs2 = 5'd0; hz_i_data_rs2 = 32'h1234;
    hz_i_addr_rs1 = 5'd9; hz_i_data_rs1 = 32'hCAFE;
    hz_i_ce = 1'b1;
    settle();
    checks++; if (hz_o_data_rs2 !== 32'h0) begin errors++; $display("FAIL x0_data: got %h want 00000000", hz_o_data_rs2); end
    checks++; if (hz_o_data_rs1 !== 32'hCAFE) begin errors++; $display("FAIL x0_rf_passthru: got %h want 0000cafe", hz_o_data_rs1); end
    checks++; if (hz_o_stall !== 1'b0) begin errors++; $display("FAIL x0_no_stall: got %0b want 0", hz_o_stall); end
    idle();
    tick();
  endtask

  task automatic test_load_use();
    idle();
    set_stage(0, 1, 1, 0, 5'd7, 32'hDEAD0001);
    hz_i_addr_rs1 = 5'd7; hz_i_ce = 1'b1;
    settle();
    checks++; if (hz_o_stall !== 1'b1) begin errors++; $display("FAIL lu_stall: got %0b want 1", hz_o_stall); end
    checks++; if (hz_o_flush !== 1'b0) begin errors++; $display("FAIL lu_flush: got %0b want 0", hz_o_flush); end
    tick();
    set_stage(0, 1, 1, 1, 5'd7, 32'hDEAD0001);
    settle();
    checks++; if (hz_o_stall !== 1'b0) begin errors++; $display("FAIL lu_release: got %0b want 0", hz_o_stall); end
    checks++; if (hz_o_data_rs1 !== 32'hDEAD0001) begin errors++; $display("FAIL lu_data: got %h want dead0001", hz_o_data_rs1); end
    checks++; if (hz_o_stall_cnt !== 16'd1) begin errors++; $display("FAIL lu_stall_cnt: got %0d want 1", hz_o_stall_cnt); end
    // Older stage not ready, but a younger ready stage shadows it.
    set_stage(1, 1, 1, 0, 5'd7, 32'h00000BAD);
    hz_i_addr_rs2 = 5'd7;
    settle();
    checks++; if (hz_o_stall !== 1'b0) begin errors++; $display("FAIL lu_shadowed: got %0b want 0", hz_o_stall); end
    checks++; if (hz_o_data_rs2 !== 32'hDEAD0001) begin errors++; $display("FAIL lu_shadow_data: got %h want dead0001", hz_o_data_rs2); end
    set_stage(0, 0, 1, 1, 5'd7, 32'hDEAD0001);
    settle();
    checks++; if (hz_o_stall !== 1'b1) begin errors++; $display("FAIL lu_older_notok: got %0b want 1", hz_o_stall); end
    hz_i_ce = 1'b0;
    settle();
    checks++; if (hz_o_stall !== 1'b0) begin errors++; $display("FAIL lu_no_ce: got %0b want 0", hz_o_stall); end
    idle();
    tick();
    checks++; if (hz_o_stall_cnt !== 16'd1) begin errors++; $display("FAIL lu_cnt_hold: got %0d want 1", hz_o_stall_cnt); end
  endtask

  task automatic test_flush_window();
    idle();
    hz_i_change_pc = 1'b1;
    set_stage(0, 1, 1, 0, 5'd7, 32'h77);
    hz_i_addr_rs1 = 5'd7; hz_i_ce = 1'b1;
    settle();
    checks++; if (hz_o_flush !== 1'b1) begin errors++; $display("FAIL fw_t0_flush: got %0b want 1", hz_o_flush); end
    checks++; if (hz_o_stall !== 1'b0) begin errors++; $display("FAIL fw_t0_stall: got %0b want 0", hz_o_stall); end
    tick();
    hz_i_change_pc = 1'b0;
    settle();
    checks++; if (hz_o_flush !== 1'b1) begin errors++; $display("FAIL fw_t1_flush: got %0b want 1", hz_o_flush); end
    checks++; if (hz_o_stall !== 1'b0) begin errors++; $display("FAIL fw_t1_stall: got %0b want 0", hz_o_stall); end
    tick();
    hz_i_ce = 1'b0;
    settle();
    checks++; if (hz_o_flush !== 1'b0) begin errors++; $display("FAIL fw_t2_flush: got %0b want 0", hz_o_flush); end
    checks++; if (hz_o_flush_cnt !== 16'd1) begin errors++; $display("FAIL fw_flush_cnt1: got %0d want 1", hz_o_flush_cnt); end
    checks++; if (hz_o_stall_cnt !== 16'd1) begin errors++; $display("FAIL fw_no_stall_count: got %0d want 1", hz_o_stall_cnt); end
    // Back-to-back redirects extend the window.
    idle();
    hz_i_change_pc = 1'b1;
    settle();
    checks++; if (hz_o_flush !== 1'b1) begin errors++; $display("FAIL fw2_t0: got %0b want 1", hz_o_flush); end
    tick();
    settle();
    checks++; if (hz_o_flush !== 1'b1) begin errors++; $display("FAIL fw2_t1: got %0b want 1", hz_o_flush); end
    tick();
    hz_i_change_pc = 1'b0;
    settle();
    checks++; if (hz_o_flush !== 1'b1) begin errors++; $display("FAIL fw2_t2: got %0b want 1", hz_o_flush); end
    tick();
    settle();
    checks++; if (hz_o_flush !== 1'b0) begin errors++; $display("FAIL fw2_t3: got %0b want 0", hz_o_flush); end
    checks++; if (hz_o_flush_cnt !== 16'd3) begin errors++; $display("FAIL fw_flush_cnt3: got %0d want 3", hz_o_flush_cnt); end
    idle();
    tick();
  endtask

  task automatic test_watchdog();
    idle();
    hz_i_ce = 1'b1; hz_i_alu_busy = 1'b1;
    settle();
    for (int k = 1; k <= 15; k++) begin
      checks++; if (hz_o_stall !== 1'b1) begin errors++; $display("FAIL wd_stall_%0d: got %0b want 1", k, hz_o_stall); end
      checks++; if (hz_o_timeout !== 1'b0) begin errors++; $display("FAIL wd_early_%0d: got %0b want 0", k, hz_o_timeout); end
      tick();
      settle();
    end
    checks++; if (hz_o_timeout !== 1'b1) begin errors++; $display("FAIL wd_trip: got %0b want 1", hz_o_timeout); end
    checks++; if (hz_o_stall_cnt !== 16'd16) begin errors++; $display("FAIL wd_stall_cnt: got %0d want 16", hz_o_stall_cnt); end
    hz_i_ce = 1'b0; hz_i_alu_busy = 1'b0;
    tick();
    tick();
    settle();
    checks++; if (hz_o_timeout !== 1'b1) begin errors++; $display("FAIL wd_sticky: got %0b want 1", hz_o_timeout); end
    checks++; if (hz_o_stall_cnt !== 16'd16) begin errors++; $display("FAIL wd_cnt_hold: got %0d want 16", hz_o_stall_cnt); end
    // Clear coincides with a redirect: clear wins, redirect not counted.
    hz_i_clr = 1'b1; hz_i_change_pc = 1'b1;
    tick();
    hz_i_clr = 1'b0; hz_i_change_pc = 1'b0;
    settle();
    checks++; if (hz_o_timeout !== 1'b0) begin errors++; $display("FAIL clr_timeout: got %0b want 0", hz_o_timeout); end
    checks++; if (hz_o_stall_cnt !== 16'd0) begin errors++; $display("FAIL clr_stall_cnt: got %0d want 0", hz_o_stall_cnt); end
    checks++; if (hz_o_flush_cnt !== 16'd0) begin errors++; $display("FAIL clr_flush_cnt: got %0d want 0", hz_o_flush_cnt); end
    tick();
    tick();
  endtask

  task automatic test_async_reset();
    idle();
    hz_i_change_pc = 1'b1;
    settle();
    tick();
    hz_i_change_pc = 1'b0; hz_i_ce = 1'b1; hz_i_alu_busy = 1'b1;
    settle();
    checks++; if (hz_o_flush !== 1'b1) begin errors++; $display("FAIL ar_pre_flush: got %0b want 1", hz_o_flush); end
    checks++; if (hz_o_flush_cnt !== 16'd1) begin errors++; $display("FAIL ar_pre_cnt: got %0d want 1", hz_o_flush_cnt); end
    #2 hz_rst = 1'b1;
    #1;
    checks++; if (hz_o_flush !== 1'b1) begin errors++; $display("FAIL ar_flush: got %0b want 1", hz_o_flush); end
    checks++; if (hz_o_stall !== 1'b0) begin errors++; $display("FAIL ar_stall: got %0b want 0", hz_o_stall); end
    checks++; if (hz_o_flush_cnt !== 16'd0) begin errors++; $display("FAIL ar_cnt_async: got %0d want 0", hz_o_flush_cnt); end
    #1 hz_rst = 1'b0; hz_i_ce = 1'b0; hz_i_alu_busy = 1'b0;
    #1;
    checks++; if (hz_o_flush !== 1'b0) begin errors++; $display("FAIL ar_release_flush: got %0b want 0", hz_o_flush); end
    tick();
    settle();
    checks++; if (hz_o_flush !== 1'b0) begin errors++; $display("FAIL ar_next_flush: got %0b want 0", hz_o_flush); end
    // Reset in the middle of a stall.
    hz_i_ce = 1'b1; hz_i_alu_busy = 1'b1;
    settle();
    checks++; if (hz_o_stall !== 1'b1) begin errors++; $display("FAIL ar_stall_pre: got %0b want 1", hz_o_stall); end
    tick();
    checks++; if (hz_o_stall_cnt !== 16'd1) begin errors++; $display("FAIL ar_stall_cnt_pre: got %0d want 1", hz_o_stall_cnt); end
    #1 hz_rst = 1'b1;
    #1;
    checks++; if (hz_o_stall !== 1'b0) begin errors++; $display("FAIL ar_mid_stall: got %0b want 0", hz_o_stall); end
    checks++; if (hz_o_stall_cnt !== 16'd0) begin errors++; $display("FAIL ar_stall_cnt: got %0d want 0", hz_o_stall_cnt); end
    hz_rst = 1'b0;
    idle();
    tick();
    settle();
    checks++; if (hz_o_flush !== 1'b0) begin errors++; $display("FAIL ar_final_flush: got %0b want 0", hz_o_flush); end
    checks++; if (hz_o_stall_cnt !== 16'd0) begin errors++; $display("FAIL ar_final_cnt: got %0d want 0", hz_o_stall_cnt); end
  endtask

  initial begin
    test_reset();
    test_priority_fwd();
    test_x0_guard();
    test_load_use();
    test_flush_window();
    test_watchdog();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
